// File: rtl/mips8_pkg.sv
// rtl/mips8_pkg.sv - shared widths and stage control bundle for the 8-bit MIPS pipeline
package mips8_pkg;

  localparam int DATA_W    = 8;
  localparam int REG_W     = 3;
  localparam int DM_DEPTH  = 32;
  localparam int DM_ADDR_W = 5;

  // Control bits that travel with an instruction between execute, memory and write-back.
  typedef struct packed {
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [REG_W-1:0] rd;
  } stage_ctrl_t;

endpackage

// File: rtl/data_memory_array.sv
// rtl/data_memory_array.sv - DEPTH x DATA_W data memory, synchronous write/clear, combinational read
module data_memory_array
  import mips8_pkg::*;
#(
  parameter int DATA_W = mips8_pkg::DATA_W,
  parameter int DEPTH  = DM_DEPTH,
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_stage.sv
// rtl/data_memory_stage.sv - MIPS8 memory-access stage: range check, load/store, result register
module data_memory_stage
  import mips8_pkg::*;
#(
  parameter int DATA_W = mips8_pkg::DATA_W,
  parameter int DEPTH  = DM_DEPTH,
  parameter int ADDR_W = DM_ADDR_W,
  parameter int REG_W  = mips8_pkg::REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ex,
  input  logic [DATA_W-1:0] alu_ans_ex,
  input  logic [DATA_W-1:0] store_data_ex,
  input  logic [REG_W-1:0]  rd_ex,
  input  logic              mem_read_ex,
  input  logic              mem_write_ex,
  input  logic              reg_write_ex,
  input  logic              stall,
  output logic [DATA_W-1:0] mux_ans_dm,
  output logic [REG_W-1:0]  rd_dm,
  output logic              reg_write_dm,
  output logic              valid_dm,
  output logic              addr_err_dm
);

  localparam logic [DATA_W-1:0] DEPTH_LIMIT = DATA_W'(DEPTH);

  stage_ctrl_t       ctrl_ex;
  logic              in_range;
  logic              mem_we;
  logic [DATA_W-1:0] rdata;

  assign ctrl_ex = '{mem_read: mem_read_ex, mem_write: mem_write_ex,
                     reg_write: reg_write_ex, rd: rd_ex};

  // Addresses at or above DEPTH are errors, never aliases of low entries.
  assign in_range = (alu_ans_ex < DEPTH_LIMIT);
  assign mem_we   = !stall && valid_ex && ctrl_ex.mem_write && in_range;

  data_memory_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .reset(reset),
    .we   (mem_we),
    .addr (alu_ans_ex[ADDR_W-1:0]),
    .wdata(store_data_ex),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mux_ans_dm   <= '0;
      rd_dm        <= '0;
      reg_write_dm <= 1'b0;
      valid_dm     <= 1'b0;
      addr_err_dm  <= 1'b0;
    end else if (!stall) begin
      if (valid_ex) begin
        // A store wins when both memory strobes are set.
        if (ctrl_ex.mem_write) begin
          mux_ans_dm   <= alu_ans_ex;
          reg_write_dm <= 1'b0;
        end else if (ctrl_ex.mem_read) begin
          mux_ans_dm   <= in_range ? rdata : '0;
          reg_write_dm <= ctrl_ex.reg_write;
        end else begin
          mux_ans_dm   <= alu_ans_ex;
          reg_write_dm <= ctrl_ex.reg_write;
        end
        addr_err_dm <= (ctrl_ex.mem_read || ctrl_ex.mem_write) && !in_range;
        rd_dm       <= ctrl_ex.rd;
        valid_dm    <= 1'b1;
      end else begin
        valid_dm     <= 1'b0;
        reg_write_dm <= 1'b0;
        addr_err_dm  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_stage.sv
// tb/tb_data_memory_stage.sv - scoreboard bench for data_memory_stage against a behavioural model
module tb_data_memory_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_ex = 1'b0;
  logic [7:0] alu_ans_ex = '0;
  logic [7:0] store_data_ex = '0;
  logic [2:0] rd_ex = '0;
  logic       mem_read_ex = 1'b0;
  logic       mem_write_ex = 1'b0;
  logic       reg_write_ex = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] mux_ans_dm;
  logic [2:0] rd_dm;
  logic       reg_write_dm;
  logic       valid_dm;
  logic       addr_err_dm;

  int checks = 0;
  int errors = 0;

  data_memory_stage dut (
    .clk          (clk),
    .reset        (reset),
    .valid_ex     (valid_ex),
    .alu_ans_ex   (alu_ans_ex),
    .store_data_ex(store_data_ex),
    .rd_ex        (rd_ex),
    .mem_read_ex  (mem_read_ex),
    .mem_write_ex (mem_write_ex),
    .reg_write_ex (reg_write_ex),
    .stall        (stall),
    .mux_ans_dm   (mux_ans_dm),
    .rd_dm        (rd_dm),
    .reg_write_dm (reg_write_dm),
    .valid_dm     (valid_dm),
    .addr_err_dm  (addr_err_dm)
  );

  always #5 clk = ~clk;

  // Expected output word: {ans[7:0], rd[2:0], reg_write, valid, addr_err}
  logic [13:0] exp_q[$];

  byte unsigned m_mem [32];
  byte unsigned m_ans = 0;
  int unsigned  m_rd = 0;
  bit           m_rw = 0, m_v = 0, m_err = 0;

  always @(posedge clk) begin
    int unsigned a;
    a = alu_ans_ex;
    if (reset) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_ans = 0; m_rd = 0; m_rw = 0; m_v = 0; m_err = 0;
    end else if (!stall) begin
      if (valid_ex) begin
        if (mem_write_ex) begin
          if (a < 32) m_mem[a] = store_data_ex;
          m_ans = alu_ans_ex;
          m_rw  = 0;
        end else if (mem_read_ex) begin
          m_ans = (a < 32) ? m_mem[a] : 8'd0;
          m_rw  = reg_write_ex;
        end else begin
          m_ans = alu_ans_ex;
          m_rw  = reg_write_ex;
        end
        m_err = (mem_read_ex || mem_write_ex) && (a >= 32);
        m_rd  = rd_ex;
        m_v   = 1;
      end else begin
        m_v = 0; m_rw = 0; m_err = 0;
      end
    end
    exp_q.push_back({m_ans, m_rd[2:0], m_rw, m_v, m_err});
  end

  always begin
    logic [13:0] got, exp;
    @(posedge clk);
    #1;
    got = {mux_ans_dm, rd_dm, reg_write_dm, valid_dm, addr_err_dm};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t: no expected entry for output %h", $time, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL stage_out at %0t: got ans=%h rd=%0d rw=%b v=%b err=%b, required ans=%h rd=%0d rw=%b v=%b err=%b",
                 $time, got[13:6], got[5:3], got[2], got[1], got[0],
                 exp[13:6], exp[5:3], exp[2], exp[1], exp[0]);
      end
    end
  end

  task automatic drive(input logic r, input logic s, input logic v, input logic [7:0] a,
                       input logic [7:0] d, input logic [2:0] rdi,
                       input logic mr, input logic mw, input logic rw);
    @(negedge clk);
    reset = r; stall = s; valid_ex = v; alu_ans_ex = a; store_data_ex = d;
    rd_ex = rdi; mem_read_ex = mr; mem_write_ex = mw; reg_write_ex = rw;
  endtask

  initial begin
    // Reset held over a store request to addr 3, then read addr 3 back.
    drive(1, 0, 1, 8'h03, 8'h77, 3'd1, 0, 1, 0);
    drive(1, 0, 1, 8'h03, 8'h77, 3'd1, 0, 1, 0);
    drive(0, 0, 1, 8'h03, 8'h00, 3'd1, 1, 0, 1);
    // Back-to-back store then load.
    drive(0, 0, 1, 8'h07, 8'hA5, 3'd0, 0, 1, 1);
    drive(0, 0, 1, 8'h07, 8'h00, 3'd2, 1, 0, 1);
    // ALU pass-through.
    drive(0, 0, 1, 8'hFF, 8'h00, 3'd5, 0, 0, 1);
    drive(0, 0, 1, 8'h0F, 8'h00, 3'd5, 0, 0, 1);
    // Out-of-range store, then loads at 5, 0x20, and boundary 0x1F.
    drive(0, 0, 1, 8'h25, 8'h55, 3'd3, 0, 1, 1);
    drive(0, 0, 1, 8'h05, 8'h00, 3'd4, 1, 0, 1);
    drive(0, 0, 1, 8'h20, 8'h00, 3'd4, 1, 0, 1);
    drive(0, 0, 1, 8'h1F, 8'h3C, 3'd6, 1, 1, 1);
    drive(0, 0, 1, 8'h1F, 8'h00, 3'd6, 1, 0, 1);
    // Stall with changing stores, then a bubble, then verify memory frozen.
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 8'(i + 8), 8'(8'h90 + i), 3'(i), 0, 1, 1);
    drive(0, 0, 0, 8'h11, 8'h00, 3'd7, 1, 0, 1);
    drive(0, 0, 1, 8'h08, 8'h00, 3'd1, 1, 0, 1);
    drive(0, 0, 1, 8'h07, 8'h00, 3'd1, 1, 0, 1);
    // Reset during stall wins and clears memory.
    drive(0, 1, 1, 8'h07, 8'h00, 3'd1, 1, 0, 1);
    drive(1, 1, 1, 8'h07, 8'h00, 3'd1, 1, 0, 1);
    drive(0, 0, 1, 8'h07, 8'h00, 3'd2, 1, 0, 1);
    drive(0, 0, 1, 8'h1F, 8'h00, 3'd2, 1, 0, 1);
    // Randomised traffic focused around the address boundary.
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 5) != 0), a, 8'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
    end
    drive(0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required at most 1", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_stage.md
Name: data_memory_stage

Overview:
Memory-access stage of the 8-bit MIPS pipeline, directly upstream of the write-back stage. It takes the execute-stage ALU answer and control bits and performs a load or store on a 32x8 data memory. It registers the selected result, ALU answer or loaded byte, as mux_ans_dm, which feeds the write-back stage. It also carries the destination register and write enable forward, with pipeline valid and stall control.

Parameters:
DATA_W, 8, datapath width in bits
DEPTH, 32, data memory entries
ADDR_W, 5, memory index width (log2 DEPTH)
REG_W, 3, register-file index width

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
valid_ex  in  1  execute-stage instruction valid
alu_ans_ex  in  8  ALU result; used as memory address for load/store
store_data_ex  in  8  data to store (rt value)
rd_ex  in  3  destination register index
mem_read_ex  in  1  load instruction
mem_write_ex  in  1  store instruction
reg_write_ex  in  1  instruction writes register file
stall  in  1  hold stage: no state change
mux_ans_dm  out  8  registered result to write-back stage
rd_dm  out  3  registered destination index
reg_write_dm  out  1  registered register-write enable
valid_dm  out  1  registered valid
addr_err_dm  out  1  registered flag: load/store address >= DEPTH

Behaviour:
- Reset (reset=1 at rising edge), highest priority over stall and valid:
  - mux_ans_dm=0, rd_dm=0, reg_write_dm=0, valid_dm=0, addr_err_dm=0.
  - All DEPTH memory entries cleared to 0.
- Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N.
- stall=1 (reset=0): all outputs and memory contents hold; the input is not consumed.
- stall=0, valid_ex=0 (bubble):
  - valid_dm=0, reg_write_dm=0, addr_err_dm=0.
  - mux_ans_dm and rd_dm hold.
  - Memory is not written.
- stall=0, valid_ex=1:
  - in_range = (alu_ans_ex < DEPTH); index = alu_ans_ex[ADDR_W-1:0].
  - Store (mem_write_ex=1): if in_range, mem[index] <= store_data_ex. mux_ans_dm <= alu_ans_ex; reg_write_dm <= 0.
  - Load (mem_read_ex=1, mem_write_ex=0): mux_ans_dm <= in_range ? mem[index] : 0. reg_write_dm <= reg_write_ex.
  - Neither: mux_ans_dm <= alu_ans_ex; reg_write_dm <= reg_write_ex.
  - Both mem_read_ex and mem_write_ex set: treated as a store; the load is ignored.
  - addr_err_dm <= (mem_read_ex | mem_write_ex) & ~in_range. An out-of-range store leaves memory untouched.
  - rd_dm <= rd_ex; valid_dm <= 1.
- Memory read is combinational from the array, sampled into mux_ans_dm at the edge.
  - A store at edge N is visible to a load sampled at edge N+1 (back-to-back store/load returns new data).
  - No same-edge read-during-write case exists, since one instruction per cycle.
- Address wrap: none. Addresses 32..255 are errors, not aliases.

Decomposition:
- Shared package mips8_pkg: constants DATA_W, REG_W, DM_DEPTH, DM_ADDR_W. Stage control bundle typedef (mem_read, mem_write, reg_write, rd) for reuse by the execute and write-back stages.
- One sub-module, data_memory_array:
  - DEPTH x DATA_W storage.
  - Synchronous write enable, combinational read port.
  - Synchronous clear on reset.
- The stage wrapper holds the range check, result mux and pipeline registers.

Test Plan:
- Reset: drive reset=1 for 2 edges with valid_ex=1, store to addr 3 -> all outputs 0; mem[3] reads back 0 after reset release.
- Store/load back-to-back: edge1 store 0xA5 to addr 0x07; edge2 load 0x07, reg_write_ex=1, rd_ex=2 -> mux_ans_dm=0xA5, rd_dm=2, reg_write_dm=1, valid_dm=1.
- ALU pass-through: valid_ex=1, no mem op, alu_ans_ex=0xFF, reg_write_ex=1, rd_ex=5 -> next cycle mux_ans_dm=0xFF, reg_write_dm=1; then alu_ans_ex=0x0F -> mux_ans_dm=0x0F.
- Out-of-range: store 0x55 to addr 0x25, then load 0x05 -> addr_err_dm=1 after the store, mem[5] unchanged (0), load returns 0; load from 0x20 -> mux_ans_dm=0, addr_err_dm=1.
- Stall/bubble: stall=1 for 3 cycles with a changing store request -> outputs and memory frozen. Then valid_ex=0 -> valid_dm=0, reg_write_dm=0, mux_ans_dm holds the prior value.
- Reset mid-stall: stall=1 and reset=1 on the same edge -> reset wins; outputs 0 and memory cleared.
